// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants, types and helpers for the audio output path.
//   AUDIO_SLOT_BITS     : bits per I2S slot (one channel word on the wire)
//   AUDIO_TICKS_PER_BIT : divider ticks per BCLK period
//   AUDIO_FRAME_TICKS   : divider ticks per stereo frame
//   AUDIO_DEFAULT_DIV   : system clocks per tick for 22.05 kHz at 100 MHz
//   audio_sample_t      : signed 16-bit PCM sample
//   audio_state_e       : framer run state
//   audio_eff_div()     : maps a divider setting of 0 to 1
package audio_pkg;

  localparam int AUDIO_SLOT_BITS     = 32;
  localparam int AUDIO_TICKS_PER_BIT = 4;
  localparam int AUDIO_FRAME_TICKS   = 256;
  localparam int AUDIO_DEFAULT_DIV   = 100_000_000 / (256 * 22050);

  typedef logic signed [15:0] audio_sample_t;

  // WAIT_FIRST: enabled (or freshly reset) but the first frame has not started.
  // RUN       : frames are being emitted back to back.
  typedef enum logic {
    AUDIO_ST_WAIT_FIRST = 1'b0,
    AUDIO_ST_RUN        = 1'b1
  } audio_state_e;

  function automatic logic [31:0] audio_eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/audio_tick_divider.sv
// audio_tick_divider
// Divides the system clock down to the 256*fs tick rate.
//   i_clock   : system clock
//   i_reset   : asynchronous active-low reset
//   i_enable  : low holds the counter at 0 and suppresses ticks
//   i_eff_div : effective divider, always >= 1
//   o_tick    : high for one clock in the cycle where the count reaches i_eff_div-1
module audio_tick_divider
  import audio_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_eff_div,
  output logic        o_tick
);

  logic [31:0] div_cnt_q;
  logic [31:0] div_cnt_d;

  // ">=" rather than "==" so that a divider that shrinks below the current
  // count (possible while waiting for the first frame) still ticks promptly
  // instead of running the counter round the full 32-bit range.
  assign o_tick = i_enable && (div_cnt_q >= (i_eff_div - 32'd1));

  always_comb begin
    div_cnt_d = div_cnt_q + 32'd1;
    if (!i_enable || o_tick) begin
      div_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      div_cnt_q <= 32'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/audio_i2s_output.sv
// audio_i2s_output
// Serialises the mixer's stereo samples onto an I2S link and requests the
// next sample once per frame.
//   i_clock           : system clock
//   i_reset           : asynchronous active-low reset
//   i_enable          : run enable; low forces the link idle
//   i_sample_rate_div : system clocks per tick, taken at each frame start
//   i_sample_left     : signed left sample, taken at each frame start
//   i_sample_right    : signed right sample, taken at each frame start
//   o_sample_clock    : one-cycle pulse per frame start
//   o_i2s_bclk        : bit clock (64*fs)
//   o_i2s_lrck        : word select, 0 = left slot, 1 = right slot
//   o_i2s_sdata       : serial data, MSB first, one-bit I2S delay
//   o_frame_count     : frames emitted since reset or enable rise
module audio_i2s_output
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [31:0]                   i_sample_rate_div,
  input  logic signed [SAMPLE_BITS-1:0] i_sample_left,
  input  logic signed [SAMPLE_BITS-1:0] i_sample_right,
  output logic                          o_sample_clock,
  output logic                          o_i2s_bclk,
  output logic                          o_i2s_lrck,
  output logic                          o_i2s_sdata,
  output logic [31:0]                   o_frame_count
);

  localparam logic [7:0] LAST_TICK = 8'(AUDIO_FRAME_TICKS - 1);
  localparam logic [4:0] MSB_SLOT_BIT = 5'(SAMPLE_BITS);

  audio_state_e            state_q, state_d;
  logic [7:0]              tc_q, tc_d;
  logic [SAMPLE_BITS-1:0]  shadow_l_q, shadow_l_d;
  logic [SAMPLE_BITS-1:0]  shadow_r_q, shadow_r_d;
  logic [31:0]             latched_div_q, latched_div_d;
  logic                    sample_clock_q, sample_clock_d;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic [31:0]             frame_count_q, frame_count_d;

  logic                       tick;
  logic                       frame_start;
  logic [31:0]                eff_div;
  logic [4:0]                 slot_bit;
  logic [4:0]                 word_pos;
  logic [SAMPLE_BITS-1:0]     word;
  logic [AUDIO_SLOT_BITS-1:0] word_ext;

  // Before the first frame the live divider input sets the wait, so the
  // first frame starts eff_div cycles after enable (or reset release) even
  // though the latched copy is still cleared. That first tick latches it.
  assign eff_div = audio_eff_div((state_q == AUDIO_ST_RUN) ? latched_div_q
                                                           : i_sample_rate_div);

  audio_tick_divider u_tick_divider (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_eff_div (eff_div),
    .o_tick    (tick)
  );

  // tick already implies i_enable, so a disable in the same cycle wins.
  assign frame_start = tick && ((state_q == AUDIO_ST_WAIT_FIRST) || (tc_q == LAST_TICK));

  always_comb begin
    state_d        = state_q;
    tc_d           = tc_q;
    shadow_l_d     = shadow_l_q;
    shadow_r_d     = shadow_r_q;
    latched_div_d  = latched_div_q;
    sample_clock_d = 1'b0;
    frame_count_d  = frame_count_q;

    if (!i_enable) begin
      state_d = AUDIO_ST_WAIT_FIRST;
      tc_d    = 8'd0;
    end else begin
      if (tick) begin
        state_d = AUDIO_ST_RUN;
        // The first tick after enable is itself tick 0 of the first frame.
        tc_d    = (state_q == AUDIO_ST_RUN) ? tc_q + 8'd1 : 8'd0;
      end
      if (frame_start) begin
        shadow_l_d     = i_sample_left;
        shadow_r_d     = i_sample_right;
        latched_div_d  = i_sample_rate_div;
        sample_clock_d = 1'b1;
      end
      // Waiting for the first frame doubles as the "just enabled" state,
      // which is where the frame count restarts.
      if (state_q == AUDIO_ST_WAIT_FIRST) begin
        frame_count_d = frame_start ? 32'd1 : 32'd0;
      end else if (frame_start) begin
        frame_count_d = frame_count_q + 32'd1;
      end
    end

    // Serial lines follow the next tick count and the next shadow words, so
    // they change in the cycle after each tick and the first frame after a
    // frame-start never shows stale samples. tc = 0 gives an all-zero idle.
    slot_bit = tc_d[6:2];
    word     = tc_d[7] ? shadow_r_d : shadow_l_d;
    word_ext = {{(AUDIO_SLOT_BITS - SAMPLE_BITS){1'b0}}, word};
    word_pos = MSB_SLOT_BIT - slot_bit;
    bclk_d   = tc_d[1];
    lrck_d   = tc_d[7];
    // Slot bit 0 is the I2S delay bit; bits past the sample are zero padding.
    sdata_d  = ((slot_bit != 5'd0) && (slot_bit <= MSB_SLOT_BIT)) ? word_ext[word_pos] : 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= AUDIO_ST_WAIT_FIRST;
      tc_q           <= 8'd0;
      shadow_l_q     <= '0;
      shadow_r_q     <= '0;
      latched_div_q  <= 32'd0;
      sample_clock_q <= 1'b0;
      bclk_q         <= 1'b0;
      lrck_q         <= 1'b0;
      sdata_q        <= 1'b0;
      frame_count_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      tc_q           <= tc_d;
      shadow_l_q     <= shadow_l_d;
      shadow_r_q     <= shadow_r_d;
      latched_div_q  <= latched_div_d;
      sample_clock_q <= sample_clock_d;
      bclk_q         <= bclk_d;
      lrck_q         <= lrck_d;
      sdata_q        <= sdata_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign o_sample_clock = sample_clock_q;
  assign o_i2s_bclk     = bclk_q;
  assign o_i2s_lrck     = lrck_q;
  assign o_i2s_sdata    = sdata_q;
  assign o_frame_count  = frame_count_q;

endmodule

// File: tb/tb_audio_i2s_output.sv
// tb_audio_i2s_output
// Self-checking bench for audio_i2s_output. The expected waveform is derived
// from the frame timeline: a frame starting at cycle P with divider d has
// tick k at cycle P + k*d, BCLK high for ticks 2-3 of each 4-tick bit, LRCK
// set for bits 32..63, and slot bit b carrying sample bit 16-b for b=1..16.
module tb_audio_i2s_output;
  import audio_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [31:0]   div = 32'd0;
  audio_sample_t left = '0;
  audio_sample_t right = '0;

  logic        sample_clock;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic [31:0] frame_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Pending mid-frame input change, applied by step() when its cycle arrives.
  bit          chg_pending = 1'b0;
  int          chg_cyc = 0;
  logic [15:0] chg_l = '0;
  logic [15:0] chg_r = '0;
  logic [31:0] chg_div = '0;

  audio_i2s_output #(.SAMPLE_BITS(16)) dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_enable          (en),
    .i_sample_rate_div (div),
    .i_sample_left     (left),
    .i_sample_right    (right),
    .o_sample_clock    (sample_clock),
    .o_i2s_bclk        (bclk),
    .o_i2s_lrck        (lrck),
    .o_i2s_sdata       (sdata),
    .o_frame_count     (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff(input logic [31:0] d);
    return (d == 32'd0) ? 1 : int'(d);
  endfunction

  function automatic logic exp_bit(input int n, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] w;
    int b;
    w = (n >= 32) ? r : l;
    b = n % 32;
    return (b >= 1 && b <= 16) ? w[16 - b] : 1'b0;
  endfunction

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic step(input int t);
    if (chg_pending && chg_cyc <= t) begin
      goto(chg_cyc);
      left = chg_l;
      right = chg_r;
      div = chg_div;
      chg_pending = 1'b0;
    end
    goto(t);
  endtask

  task automatic wait_pulse(input int maxc, input string nm, output int pc);
    pc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (sample_clock === 1'b1) begin
        pc = cyc;
        break;
      end
    end
    if (pc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_pulse_timeout: no o_sample_clock within %0d cycles", nm, maxc);
    end
  endtask

  // Disable briefly, program the inputs, enable; expect the first pulse
  // eff_div cycles later with the frame count restarted at 1.
  task automatic restart(input logic [31:0] d, input logic [15:0] l, input logic [15:0] r,
                         input string nm, output int pc);
    int c;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    div = d;
    left = l;
    right = r;
    en = 1'b1;
    c = cyc;
    wait_pulse(eff(d) + 4, nm, pc);
    checks++;
    if (pc - c != eff(d)) begin
      failures++;
      $display("FAIL %s_first_latency: got %0d cycles want %0d", nm, pc - c, eff(d));
    end
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL %s_first_count: got %0d want 1", nm, frame_count);
    end
  endtask

  // Walk one frame starting at pulse cycle p. A nonzero chg_tick applies the
  // given inputs at tick chg_tick of this frame; they must not affect it.
  task automatic check_frame(input int p, input int d, input logic [15:0] fl, input logic [15:0] fr,
                             input int chg_tick, input logic [15:0] nl, input logic [15:0] nr,
                             input logic [31:0] ndiv, input string nm);
    logic [63:0] lo_v, pre_v, hi_v, lr_v, dat_v, exp_lr, exp_dat;
    if (chg_tick > 0) begin
      chg_pending = 1'b1;
      chg_cyc = p + chg_tick * d;
      chg_l = nl;
      chg_r = nr;
      chg_div = ndiv;
    end
    for (int b = 0; b < 64; b++) begin
      exp_lr[b]  = (b >= 32);
      exp_dat[b] = exp_bit(b, fl, fr);
      step(p + 4 * b * d);
      lo_v[b] = bclk;
      if (b == 0) begin
        step(p + 1);
        checks++;
        if (sample_clock !== 1'b0) begin
          failures++;
          $display("FAIL %s_pulse_width: o_sample_clock=%b one cycle after pulse, want 0", nm, sample_clock);
        end
      end
      step(p + (4 * b + 2) * d - 1);
      pre_v[b] = bclk;
      step(p + (4 * b + 2) * d);
      hi_v[b]  = bclk;
      lr_v[b]  = lrck;
      dat_v[b] = sdata;
    end
    if (chg_pending) step(chg_cyc);
    checks++;
    if (lo_v !== 64'd0) begin
      failures++;
      $display("FAIL %s_bclk_low: got %h want 0", nm, lo_v);
    end
    checks++;
    if (pre_v !== 64'd0) begin
      failures++;
      $display("FAIL %s_bclk_rise_early: got %h want 0", nm, pre_v);
    end
    checks++;
    if (hi_v !== {64{1'b1}}) begin
      failures++;
      $display("FAIL %s_bclk_high: got %h want ffffffffffffffff", nm, hi_v);
    end
    checks++;
    if (lr_v !== exp_lr) begin
      failures++;
      $display("FAIL %s_lrck: got %h want %h", nm, lr_v, exp_lr);
    end
    checks++;
    if (dat_v !== exp_dat) begin
      failures++;
      $display("FAIL %s_sdata: got %h want %h", nm, dat_v, exp_dat);
    end
    $display("frame %s: start=%0d div=%0d L=%h R=%h bits=%h", nm, p, d, fl, fr, dat_v);
  endtask

  task automatic expect_next(input int p, input int period, input logic [31:0] fc,
                             input string nm, output int pn);
    wait_pulse(period + 16, nm, pn);
    checks++;
    if (pn - p != period) begin
      failures++;
      $display("FAIL %s_period: got %0d cycles want %0d", nm, pn - p, period);
    end
    checks++;
    if (frame_count !== fc) begin
      failures++;
      $display("FAIL %s_count: got %0d want %0d", nm, frame_count, fc);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_clock, bclk, lrck, sdata} !== 4'b0 || frame_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got clk=%b bclk=%b lrck=%b sdata=%b cnt=%0d want all 0",
               sample_clock, bclk, lrck, sdata, frame_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({sample_clock, bclk, lrck, sdata} !== 4'b0 || frame_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle: got clk=%b bclk=%b lrck=%b sdata=%b cnt=%0d want all 0",
               sample_clock, bclk, lrck, sdata, frame_count);
    end
    $display("reset: outputs idle");
  endtask

  task automatic test_divider_period();
    int p, pn;
    restart(32'd17, 16'hA5C3, 16'h0F0F, "div17", p);
    check_frame(p, 17, 16'hA5C3, 16'h0F0F, 0, '0, '0, '0, "div17_f1");
    expect_next(p, 4352, 32'd2, "div17_f2", pn);
    check_frame(pn, 17, 16'hA5C3, 16'h0F0F, 0, '0, '0, '0, "div17_f2");
    expect_next(pn, 4352, 32'd3, "div17_f3", p);
  endtask

  task automatic test_mid_frame_change();
    int p, pn;
    logic [15:0] l0, r0, l1;
    l0 = 16'($urandom);
    r0 = 16'($urandom);
    l1 = ~l0;
    restart(32'd17, l0, r0, "mid", p);
    check_frame(p, 17, l0, r0, 40, l1, r0, 32'd17, "mid_input");
    expect_next(p, 4352, 32'd2, "mid_input", pn);
    check_frame(pn, 17, l1, r0, 100, l1, r0, 32'd8, "mid_div");
    expect_next(pn, 4352, 32'd3, "mid_div_cur", p);
    check_frame(p, 8, l1, r0, 0, '0, '0, '0, "mid_div_new");
    expect_next(p, 2048, 32'd4, "mid_div_new", pn);
  endtask

  task automatic test_reset_mid_frame();
    int p, c;
    logic [15:0] l1, r1;
    restart(32'd17, 16'($urandom), 16'($urandom), "rstmid", p);
    goto(p + 130 * 17);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sample_clock, bclk, lrck, sdata} !== 4'b0 || frame_count !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async: got clk=%b bclk=%b lrck=%b sdata=%b cnt=%0d want all 0",
               sample_clock, bclk, lrck, sdata, frame_count);
    end
    repeat (3) @(negedge clk);
    l1 = 16'($urandom);
    r1 = 16'($urandom);
    left = l1;
    right = r1;
    rst_n = 1'b1;
    c = cyc;
    wait_pulse(40, "rstmid_release", p);
    checks++;
    if (p - c != 17) begin
      failures++;
      $display("FAIL rstmid_latency: got %0d cycles want 17", p - c);
    end
    checks++;
    if (frame_count !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_count: got %0d want 1", frame_count);
    end
    check_frame(p, 17, l1, r1, 0, '0, '0, '0, "rstmid_f1");
  endtask

  task automatic test_zero_div();
    int p, pn;
    logic [15:0] l0, r0;
    l0 = 16'($urandom);
    r0 = 16'($urandom);
    restart(32'd0, l0, r0, "zero", p);
    check_frame(p, 1, l0, r0, 0, '0, '0, '0, "zero_f1");
    expect_next(p, 256, 32'd2, "zero_f2", pn);
    check_frame(pn, 1, l0, r0, 0, '0, '0, '0, "zero_f2");
    expect_next(pn, 256, 32'd3, "zero_f3", p);
  endtask

  task automatic test_random_frames();
    int p, pn;
    logic [15:0] cl, cr, nl, nr;
    logic [31:0] cd, nd;
    cl = 16'($urandom);
    cr = 16'($urandom);
    cd = 32'($urandom_range(1, 4));
    restart(cd, cl, cr, "rand", p);
    for (int f = 0; f < 6; f++) begin
      nl = 16'($urandom);
      nr = 16'($urandom);
      nd = 32'($urandom_range(0, 4));
      check_frame(p, eff(cd), cl, cr, int'($urandom_range(1, 250)), nl, nr, nd, "rand");
      expect_next(p, 256 * eff(cd), 32'(f + 2), "rand", pn);
      p = pn;
      cl = nl;
      cr = nr;
      cd = nd;
    end
  endtask

  task automatic test_enable_drop();
    int p, pn, c, bad;
    logic [15:0] l0, r0;
    l0 = 16'($urandom);
    r0 = 16'($urandom);
    restart(32'd3, l0, r0, "endrop", p);
    expect_next(p, 768, 32'd2, "endrop", pn);
    // Drop enable in the very cycle of the next frame-start tick.
    goto(pn + 767);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({sample_clock, bclk, lrck, sdata} !== 4'b0 || frame_count !== 32'd2) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL endrop_idle: got %0d non-idle cycles want 0", bad);
    end
    en = 1'b1;
    c = cyc;
    @(negedge clk);
    checks++;
    if (frame_count !== 32'd0) begin
      failures++;
      $display("FAIL endrop_count_clear: got %0d want 0", frame_count);
    end
    wait_pulse(10, "endrop_reenable", p);
    checks++;
    if (p - c != 3 || frame_count !== 32'd1 || lrck !== 1'b0 || bclk !== 1'b0) begin
      failures++;
      $display("FAIL endrop_restart: got latency=%0d cnt=%0d lrck=%b bclk=%b want 3 1 0 0",
               p - c, frame_count, lrck, bclk);
    end
    check_frame(p, 3, l0, r0, 0, '0, '0, '0, "endrop_f1");
  endtask

  initial begin
    test_reset();
    test_divider_period();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_zero_div();
    test_random_frames();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_i2s_output.md
Name: audio_i2s_output

Overview:
- Serial output stage directly downstream of the 8-channel audio controller.
- Consumes the controller's mixed 16-bit left/right samples and its sample-rate divider.
- Drives an I2S codec (BCLK, LRCK, SDATA) and returns the one-cycle sample-clock pulse that the controller's channels advance on.
- Frame = 256 divider ticks = 64 BCLK periods = two 32-bit slots (left, then right).

Parameters:
SAMPLE_BITS, 16, width of the incoming PCM samples; must be 1..31.

Ports:
i_clock  input  1  system clock (100 MHz)
i_reset  input  1  asynchronous, active-low reset
i_enable  input  1  run enable; low forces idle
i_sample_rate_div  input  32  system clocks per tick (tick rate = 256*fs); sampled at frame start
i_sample_left  input  SAMPLE_BITS  signed left sample from mixer
i_sample_right  input  SAMPLE_BITS  signed right sample from mixer
o_sample_clock  output  1  one-cycle pulse per frame; request for next sample
o_i2s_bclk  output  1  bit clock, 64*fs
o_i2s_lrck  output  1  word select; 0 = left slot, 1 = right slot
o_i2s_sdata  output  1  serial data, MSB first, I2S one-bit delay
o_frame_count  output  32  frames emitted since reset or enable rise; wraps at 2^32

Behaviour:
- Reset (i_reset low, asynchronous):
  - All outputs go to 0.
  - Divider counter, tick counter, shadow samples and latched divider are cleared.
  - Output is held until the first clock edge after release.
- Divider:
  - eff_div = (latched_div == 0) ? 1 : latched_div.
  - div_cnt counts 0..eff_div-1. A tick is asserted in the cycle where div_cnt == eff_div-1; div_cnt then wraps to 0.
- Tick counter tc[7:0] advances by 1 per tick and wraps 255 -> 0.
  - bit_idx = tc[7:2] (0..63).
  - slot = bit_idx[5].
  - b = bit_idx[4:0].
- Frame start is a tick that moves tc from 255 to 0, or the first tick after enable.
  - Latch i_sample_left/right into the shadow registers.
  - Latch i_sample_rate_div. The new value governs the next frame; a mid-frame divider change never alters the current frame.
  - Pulse o_sample_clock high for exactly one i_clock cycle, registered in the cycle after the tick.
  - Increment o_frame_count.
- Serial outputs, registered and updated one cycle after each tick:
  - o_i2s_bclk = tc[1]: low for ticks 0-1 of each bit, high for ticks 2-3. Data changes on the falling edge and is stable at the rising edge.
  - o_i2s_lrck = slot.
  - o_i2s_sdata = shadow[slot][SAMPLE_BITS-b] for 1 <= b <= SAMPLE_BITS, else 0. Bit 0 of each slot is the I2S delay bit; trailing bits are zero-padded.
- First frame after enable or reset: the shadow registers are loaded at that frame's start tick, so no stale data is emitted. Sample latency from o_sample_clock to the MSB on SDATA is 4 ticks (one bit).
- i_enable low (synchronous):
  - Next cycle: div_cnt=0, tc=0, o_i2s_bclk=0, o_i2s_lrck=0, o_i2s_sdata=0.
  - No o_sample_clock pulses; o_frame_count is held.
- i_enable rising: o_frame_count clears to 0 and the first frame starts at the first tick, eff_div cycles after the rise.
- Simultaneous tick and i_enable fall: the disable wins and no pulse is emitted.
- Sample inputs are not sampled except at frame start; changes elsewhere have no effect.

Decomposition:
- Shared package audio_pkg holds:
  - AUDIO_SLOT_BITS = 32
  - AUDIO_TICKS_PER_BIT = 4
  - AUDIO_FRAME_TICKS = 256
  - AUDIO_DEFAULT_DIV = 100_000_000 / (256*22050)
  - typedef audio_sample_t (signed [15:0])
- One sub-module, audio_tick_divider. Inputs: clock, reset, enable, eff_div. Output: one-cycle tick.
- Framing and serialisation stay in audio_i2s_output.

Test Plan:
- Divider period: div=17, enable high, L=16'hA5C3, R=16'h0F0F.
  - o_sample_clock period is 4352 cycles; o_i2s_bclk period is 68 cycles; o_i2s_lrck period is 4352 cycles.
  - Left slot bits 1-16 are 1010010111000011; right slot bits 1-16 are 0000111100001111; all other bits are 0.
- Zero divider: div=0.
  - Behaves as div=1; o_sample_clock period is 256 cycles and o_i2s_bclk period is 4 cycles.
- Mid-frame divider change: change div from 17 to 8 at tc=100.
  - Current frame completes at 4352 cycles; the following frame is 2048 cycles.
- Mid-frame input change: change i_sample_left at tc=40.
  - Serialized left word is unchanged until the next frame.
- Reset mid-frame: drive i_reset low at tc=130.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release with enable high, the first pulse arrives 17 cycles later and o_frame_count = 1.
- Enable drop: drop i_enable for 1000 cycles.
  - Lines stay idle at 0 with no pulses.
  - After re-enable, o_frame_count restarts from 0 and the frame starts with LRCK = 0 and BCLK low.
